pipeline_ctrl_fsm: RTL and testbench

Central sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). Takes hazard requests from the forwarding/hazard logic, the EX-stage mispredict signal and the memory-ready handshake. Produces per-stage register enables, flush/bubble controls and the PC redirect select. Owns load-use stall timing, memory-wait freeze, halt drain, and saturating performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 53 +++++
 rtl/pipeline_ctrl_fsm_if.sv | 35 +++
 rtl/sat_counter.sv | 29 ++
 rtl/pipeline_ctrl_fsm.sv | 146 ++++++++++++++
 tb/tb_pipeline_ctrl_fsm.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stage-control presets for the RV32I pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LEFT_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        RUN        = 3'd0,
        LOAD_STALL = 3'd1,
        MEM_WAIT   = 3'd2,
        DRAIN      = 3'd3,
        HALTED     = 3'd4
    } ctrl_state_e;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    typedef struct packed {
        logic        pc_en;
        logic        pc_redirect;
        stage_ctrl_t if_id;
        stage_ctrl_t id_ex;
        logic        ex_mem_en;
        logic        mem_wb_en;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, pc_redirect: 1'b0,
        if_id: '{en: 1'b1, flush: 1'b0}, id_ex: '{en: 1'b1, flush: 1'b0},
        ex_mem_en: 1'b1, mem_wb_en: 1'b1};

    localparam pipe_ctrl_t CTRL_FLUSH = '{
        pc_en: 1'b1, pc_redirect: 1'b1,
        if_id: '{en: 1'b1, flush: 1'b1}, id_ex: '{en: 1'b1, flush: 1'b1},
        ex_mem_en: 1'b1, mem_wb_en: 1'b1};

    // Hold PC and IF/ID, push a bubble into ID/EX.
    localparam pipe_ctrl_t CTRL_STALL = '{
        pc_en: 1'b0, pc_redirect: 1'b0,
        if_id: '{en: 1'b0, flush: 1'b0}, id_ex: '{en: 1'b1, flush: 1'b1},
        ex_mem_en: 1'b1, mem_wb_en: 1'b1};

    // Stop fetch, feed NOPs behind the halting instruction, let the rest retire.
    localparam pipe_ctrl_t CTRL_DRAIN = '{
        pc_en: 1'b0, pc_redirect: 1'b0,
        if_id: '{en: 1'b1, flush: 1'b1}, id_ex: '{en: 1'b1, flush: 1'b0},
        ex_mem_en: 1'b1, mem_wb_en: 1'b1};

    localparam pipe_ctrl_t CTRL_FREEZE = '0;

endpackage

// File: rtl/pipeline_ctrl_fsm_if.sv
// Hazard-request inputs and stage-control outputs of the pipeline sequencer.
interface pipeline_ctrl_fsm_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic               load_use_req;
    logic               mispredict;
    logic               dmem_ready;
    logic               halt_req;
    logic               pc_en;
    logic               pc_redirect;
    logic               if_id_en;
    logic               if_id_flush;
    logic               id_ex_en;
    logic               id_ex_flush;
    logic               ex_mem_en;
    logic               mem_wb_en;
    logic               halted;
    logic [STATE_W-1:0] state_o;
    logic [CNT_W-1:0]   stall_cycles;
    logic [CNT_W-1:0]   flush_count;

    modport master (
        input  load_use_req, mispredict, dmem_ready, halt_req,
        output pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, halted, state_o, stall_cycles, flush_count
    );

    modport slave (
        output load_use_req, mispredict, dmem_ready, halt_req,
        input  pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, halted, state_o, stall_cycles, flush_count
    );
endinterface

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipeline_ctrl_fsm.sv
// Pipeline sequencer: stage enables/flushes, PC redirect, load-use stall,
// memory-wait freeze, halt drain and saturating performance counters.
module pipeline_ctrl_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned DRAIN_CYCLES      = 4,
    parameter int unsigned CNT_W             = 32
) (
    input  logic                clk,
    input  logic                reset,
    pipeline_ctrl_fsm_if.master bus
);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [LEFT_W-1:0]  STALL_LOAD = LEFT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    ctrl_state_e         state_q, state_d;
    ctrl_state_e         ret_state_q, ret_state_d;
    ctrl_state_e         cur_state;
    logic [LEFT_W-1:0]   stall_left_q, stall_left_d;
    logic [LEFT_W-1:0]   ret_left_q, ret_left_d;
    logic [LEFT_W-1:0]   cur_left;
    logic [DRAIN_W-1:0]  drain_left_q, drain_left_d;
    pipe_ctrl_t          ctrl;
    logic                flush_inc;
    logic                stall_inc;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    // Leaving MEM_WAIT evaluates the restored state in the same cycle.
    always_comb begin
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        stall_left_d = stall_left_q;
        ret_left_d   = ret_left_q;
        drain_left_d = drain_left_q;
        ctrl         = CTRL_RUN;
        flush_inc    = 1'b0;
        cur_state    = (state_q == MEM_WAIT) ? ret_state_q : state_q;
        cur_left     = (state_q == MEM_WAIT) ? ret_left_q : stall_left_q;

        if (cur_state == HALTED) begin
            ctrl = CTRL_FREEZE;
        end else if (!bus.dmem_ready) begin
            ctrl        = CTRL_FREEZE;
            ret_state_d = cur_state;
            ret_left_d  = cur_left;
            state_d     = MEM_WAIT;
        end else begin
            state_d      = cur_state;
            stall_left_d = cur_left;
            case (cur_state)
                RUN: begin
                    if (bus.mispredict) begin
                        ctrl      = CTRL_FLUSH;
                        flush_inc = 1'b1;
                    end else if (bus.halt_req) begin
                        ctrl         = CTRL_DRAIN;
                        drain_left_d = DRAIN_LOAD;
                        state_d      = DRAIN;
                    end else if (bus.load_use_req) begin
                        ctrl         = CTRL_STALL;
                        stall_left_d = STALL_LOAD;
                        if (STALL_LOAD != '0) begin
                            state_d = LOAD_STALL;
                        end
                    end
                end
                LOAD_STALL: begin
                    if (bus.mispredict) begin
                        ctrl         = CTRL_FLUSH;
                        flush_inc    = 1'b1;
                        stall_left_d = '0;
                        state_d      = RUN;
                    end else begin
                        ctrl         = CTRL_STALL;
                        stall_left_d = cur_left - LEFT_W'(1);
                        if (cur_left == LEFT_W'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
                DRAIN: begin
                    ctrl         = CTRL_DRAIN;
                    drain_left_d = drain_left_q - DRAIN_W'(1);
                    if (bus.mispredict) begin
                        ctrl.id_ex.flush = 1'b1;
                        flush_inc        = 1'b1;
                    end
                    if (drain_left_q == DRAIN_W'(1)) begin
                        state_d = HALTED;
                    end
                end
                default: begin
                    ctrl = CTRL_FREEZE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            ret_state_q  <= RUN;
            stall_left_q <= '0;
            ret_left_q   <= '0;
            drain_left_q <= '0;
        end else begin
            state_q      <= state_d;
            ret_state_q  <= ret_state_d;
            stall_left_q <= stall_left_d;
            ret_left_q   <= ret_left_d;
            drain_left_q <= drain_left_d;
        end
    end

    assign stall_inc = !ctrl.pc_en && (state_q != HALTED);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.pc_redirect  = ctrl.pc_redirect;
    assign bus.if_id_en     = ctrl.if_id.en;
    assign bus.if_id_flush  = ctrl.if_id.flush;
    assign bus.id_ex_en     = ctrl.id_ex.en;
    assign bus.id_ex_flush  = ctrl.id_ex.flush;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.halted       = (state_q == HALTED);
    assign bus.state_o      = state_q;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_count  = flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl_fsm.sv
// Directed bench: main sequencer (L=2, D=4, 32-bit counters) alongside a
// small one (L=1, D=2, 4-bit counters) driven with identical requests.
module tb_pipeline_ctrl_fsm;
    logic clk;
    logic reset;
    logic lu, mp, rdy, hlt;
    int   errors;
    int   checks;

    // {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    localparam logic [7:0] RUNV   = 8'b1010_1011;
    localparam logic [7:0] STALLV = 8'b0000_1111;
    localparam logic [7:0] FLUSHV = 8'b1111_1111;
    localparam logic [7:0] DRAINV = 8'b0011_1011;
    localparam logic [7:0] FREEZV = 8'b0000_0000;

    pipeline_ctrl_fsm_if #(.CNT_W(32)) u_if ();
    pipeline_ctrl_fsm_if #(.CNT_W(4))  s_if ();

    assign u_if.load_use_req = lu;
    assign u_if.mispredict   = mp;
    assign u_if.dmem_ready   = rdy;
    assign u_if.halt_req     = hlt;
    assign s_if.load_use_req = lu;
    assign s_if.mispredict   = mp;
    assign s_if.dmem_ready   = rdy;
    assign s_if.halt_req     = hlt;

    pipeline_ctrl_fsm #(.LOAD_STALL_CYCLES(2), .DRAIN_CYCLES(4), .CNT_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    pipeline_ctrl_fsm #(.LOAD_STALL_CYCLES(1), .DRAIN_CYCLES(2), .CNT_W(4)) s_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if)
    );

    logic [7:0] u_ctl, s_ctl;
    assign u_ctl = {u_if.pc_en, u_if.pc_redirect, u_if.if_id_en, u_if.if_id_flush,
                    u_if.id_ex_en, u_if.id_ex_flush, u_if.ex_mem_en, u_if.mem_wb_en};
    assign s_ctl = {s_if.pc_en, s_if.pc_redirect, s_if.if_id_en, s_if.if_id_flush,
                    s_if.id_ex_en, s_if.id_ex_flush, s_if.ex_mem_en, s_if.mem_wb_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of requests mid-period; outputs are sampled 1ns later.
    task automatic drive(input logic l, input logic m, input logic r, input logic h);
        @(negedge clk);
        lu = l; mp = m; rdy = r; hlt = h;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; lu = 1'b0; mp = 1'b0; rdy = 1'b1; hlt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; lu = 1'b0; mp = 1'b0; rdy = 1'b1; hlt = 1'b0;

        // Reset and idle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            check_eq("idle_ctl", 32'(u_ctl), 32'(RUNV));
            check_eq("idle_state", 32'(u_if.state_o), 32'd0);
        end
        check_eq("idle_stall_cnt", u_if.stall_cycles, 32'd0);
        check_eq("idle_flush_cnt", u_if.flush_count, 32'd0);
        check_eq("idle_halted", 32'(u_if.halted), 32'd0);

        // Load-use pulse: two stall cycles on main, one on small
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("lu0_ctl", 32'(u_ctl), 32'(STALLV));
        check_eq("lu0_state", 32'(u_if.state_o), 32'd0);
        check_eq("lu0_s_ctl", 32'(s_ctl), 32'(STALLV));
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("lu1_ctl", 32'(u_ctl), 32'(STALLV));
        check_eq("lu1_state", 32'(u_if.state_o), 32'd1);
        check_eq("lu1_s_ctl", 32'(s_ctl), 32'(RUNV));
        check_eq("lu1_s_state", 32'(s_if.state_o), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("lu2_ctl", 32'(u_ctl), 32'(RUNV));
        check_eq("lu2_state", 32'(u_if.state_o), 32'd0);
        check_eq("lu_stall_cnt", u_if.stall_cycles, 32'd2);
        check_eq("lu_s_stall_cnt", 32'(s_if.stall_cycles), 32'd1);

        // Mispredict beats load-use; dmem_ready=0 beats mispredict
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("mp_ctl", 32'(u_ctl), 32'(FLUSHV));
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("mp_after_ctl", 32'(u_ctl), 32'(RUNV));
        check_eq("mp_flush_cnt", u_if.flush_count, 32'd1);
        check_eq("mp_stall_cnt", u_if.stall_cycles, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("mp_frz_ctl", 32'(u_ctl), 32'(FREEZV));
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("mp_rest_ctl", 32'(u_ctl), 32'(RUNV));
        check_eq("mp_rest_state", 32'(u_if.state_o), 32'd2);
        check_eq("mp_frz_flush_cnt", u_if.flush_count, 32'd1);

        // Mispredict aborts a load stall
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("abort_ctl", 32'(u_ctl), 32'(FLUSHV));
        check_eq("abort_state", 32'(u_if.state_o), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("abort_after_state", 32'(u_if.state_o), 32'd0);
        check_eq("abort_flush_cnt", u_if.flush_count, 32'd1);

        // Memory freeze inside LOAD_STALL resumes with one stall left
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            check_eq("mw_ctl", 32'(u_ctl), 32'(FREEZV));
            check_eq("mw_state", 32'(u_if.state_o), (i == 0) ? 32'd1 : 32'd2);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("mw_resume_ctl", 32'(u_ctl), 32'(STALLV));
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("mw_done_ctl", 32'(u_ctl), 32'(RUNV));
        check_eq("mw_done_state", 32'(u_if.state_o), 32'd0);
        check_eq("mw_stall_cnt", u_if.stall_cycles, 32'd5);

        // Halt: one request cycle, four DRAIN cycles, then HALTED until reset
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("halt_ctl", 32'(u_ctl), 32'(DRAINV));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            check_eq("drain_ctl", 32'(u_ctl), 32'(DRAINV));
            check_eq("drain_state", 32'(u_if.state_o), 32'd3);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'(i % 2), 1'(i % 3 == 0), 1'(i % 4 != 1), 1'(i % 5 == 0));
            check_eq("halted_ctl", 32'(u_ctl), 32'(FREEZV));
            check_eq("halted_state", 32'(u_if.state_o), 32'd4);
            check_eq("halted_flag", 32'(u_if.halted), 32'd1);
        end
        check_eq("halted_stall_cnt", u_if.stall_cycles, 32'd5);
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("rst_ctl", 32'(u_ctl), 32'(RUNV));
        check_eq("rst_state", 32'(u_if.state_o), 32'd0);
        check_eq("rst_halted", 32'(u_if.halted), 32'd0);
        check_eq("rst_stall_cnt", u_if.stall_cycles, 32'd0);

        // Counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("sat_u_stall", u_if.stall_cycles, 32'd20);
        check_eq("sat_s_stall", 32'(s_if.stall_cycles), 32'd15);
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("sat_u_flush", u_if.flush_count, 32'd20);
        check_eq("sat_s_flush", 32'(s_if.flush_count), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
